// File: rtl/pingpong_array_ctrl.sv
// -----------------------------------------------------------------------------
// pingpong_array_ctrl
//   Two-bank ping-pong frame buffer. A writer streams elements into the fill
//   bank; once DEPTH elements have been accepted, that bank becomes full and
//   is presented whole on rd_frame until the reader acknowledges it. The
//   writer proceeds into the other bank meanwhile, and stalls only when both
//   banks are full.
//
// Parameters
//   WIDTH     element width in bits
//   DEPTH     elements per frame (power of two, >= 2)
//
// Ports
//   clk       sole clock, rising edge
//   rst       asynchronous active-high reset
//   wr_valid  writer offers wr_data
//   wr_data   next frame element
//   wr_ready  element accepted when wr_valid && wr_ready
//   rd_valid  complete frame presented on rd_frame
//   rd_frame  presented bank contents (element 0 = first written)
//   rd_ack    reader consumes presented frame
//   bank_sel  index of bank driving rd_frame
//   occ       number of full banks (0, 1, 2)
//   stall_cnt saturating count of writer stall cycles
//
// Configuration
//   PINGPONG_ARRAY_CTRL_STALL_CNT_EN : when defined, stall_cnt counts cycles
//   with wr_valid=1 and wr_ready=0 (saturating at 255); otherwise it is 0.
// -----------------------------------------------------------------------------
module pingpong_array_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_ready,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_frame [DEPTH],
   input  logic             rd_ack,
   output logic             bank_sel,
   output logic [1:0]       occ,
   output logic [7:0]       stall_cnt
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

   logic [WIDTH-1:0] bank_q [2][DEPTH];
   logic             wb_q, wb_d;
   logic             rb_q, rb_d;
   logic [IW-1:0]    widx_q, widx_d;
   logic [1:0]       full_q, full_d;

   logic             wr_fire_s;
   logic             rd_fire_s;

   // Handshake decode: the fill bank is never full unless both banks are.
   always_comb begin
      wr_ready  = !full_q[wb_q];
      rd_valid  = full_q[rb_q];
      bank_sel  = rb_q;
      occ       = {1'b0, full_q[0]} + {1'b0, full_q[1]};
      wr_fire_s = wr_valid && !full_q[wb_q];
      rd_fire_s = rd_ack && full_q[rb_q];
   end

   // Present the read bank as a whole-array select.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         rd_frame[i] = rb_q ? bank_q[1][i] : bank_q[0][i];
      end
   end

   // Next-state for pointers and full flags. Completion and ack always touch
   // different banks, so both updates are applied independently.
   always_comb begin
      wb_d   = wb_q;
      rb_d   = rb_q;
      widx_d = widx_q;
      full_d = full_q;
      if (rd_fire_s) begin
         full_d[rb_q] = 1'b0;
         rb_d         = !rb_q;
      end else begin
         rb_d = rb_q;
      end
      if (wr_fire_s) begin
         if (widx_q == LAST_IDX) begin
            full_d[wb_q] = 1'b1;
            widx_d       = {IW{1'b0}};
            wb_d         = !wb_q;
         end else begin
            widx_d = widx_q + IW'(1);
         end
      end else begin
         widx_d = widx_q;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_q   <= 1'b0;
         rb_q   <= 1'b0;
         widx_q <= {IW{1'b0}};
         full_q <= 2'b00;
      end else begin
         wb_q   <= wb_d;
         rb_q   <= rb_d;
         widx_q <= widx_d;
         full_q <= full_d;
      end
   end

   // Bank storage. Writes only land in the fill bank, which is never the
   // presented bank while rd_valid=1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DEPTH; i++) begin
               bank_q[b][i] <= {WIDTH{1'b0}};
            end
         end
      end else if (wr_fire_s) begin
         bank_q[wb_q][widx_q] <= wr_data;
      end
   end

`ifdef PINGPONG_ARRAY_CTRL_STALL_CNT_EN
   logic [7:0] stall_q, stall_d;

   // Saturating stall counter next-state.
   always_comb begin
      stall_d = stall_q;
      if (wr_valid && !wr_ready && (stall_q != 8'hFF)) begin
         stall_d = stall_q + 8'd1;
      end else begin
         stall_d = stall_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= 8'd0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pingpong_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pingpong_array_ctrl
//   Self-checking bench. The reference model keeps completed frames in a
//   queue (at most two), the partially collected frame in another queue, and
//   a count of consumed frames; the presented bank index is the parity of
//   that count.
// -----------------------------------------------------------------------------
module tb_pingpong_array_ctrl;

   localparam int W = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_valid;
   logic [W-1:0] wr_data;
   logic         wr_ready;
   logic         rd_valid;
   logic [W-1:0] rd_frame [D];
   logic         rd_ack;
   logic         bank_sel;
   logic [1:0]   occ;
   logic [7:0]   stall_cnt;

   int checks   = 0;
   int failures = 0;

   logic [D*W-1:0] frames [$];
   logic [W-1:0]   part   [$];
   int             consumed;
   int             stall_m;

   pingpong_array_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .rd_valid  (rd_valid),
      .rd_frame  (rd_frame),
      .rd_ack    (rd_ack),
      .bank_sel  (bank_sel),
      .occ       (occ),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      frames.delete();
      part.delete();
      consumed = 0;
      stall_m  = 0;
   endtask

   // Compare every output against the model's current state.
   task automatic check_model(input string tag);
      logic [D*W-1:0] f;
      int             exp_stall;
`ifdef PINGPONG_ARRAY_CTRL_STALL_CNT_EN
      exp_stall = stall_m;
`else
      exp_stall = 0;
`endif
      check_eq({tag, ".wr_ready"},  32'(wr_ready),  32'(frames.size() < 2));
      check_eq({tag, ".rd_valid"},  32'(rd_valid),  32'(frames.size() > 0));
      check_eq({tag, ".occ"},       32'(occ),       32'(frames.size()));
      check_eq({tag, ".bank_sel"},  32'(bank_sel),  32'(consumed % 2));
      check_eq({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
      if (frames.size() > 0) begin
         f = frames[0];
         for (int i = 0; i < D; i++) begin
            check_eq({tag, ".rd_frame"}, 32'(rd_frame[i]), 32'(f[i*W +: W]));
         end
      end
   endtask

   // One clock cycle: drive, check pre-edge outputs, advance model at edge.
   task automatic step(input logic wv, input logic [W-1:0] wd, input logic ack);
      logic           wfire, rfire;
      logic [D*W-1:0] nf;
      wr_valid = wv;
      wr_data  = wd;
      rd_ack   = ack;
      #1;
      check_model("cyc");
      wfire = wv && (frames.size() < 2);
      rfire = ack && (frames.size() > 0);
      if (wv && !(frames.size() < 2) && stall_m < 255) stall_m++;
      @(posedge clk);
      if (rfire) begin
         void'(frames.pop_front());
         consumed++;
      end
      if (wfire) begin
         part.push_back(wd);
         if (part.size() == D) begin
            for (int i = 0; i < D; i++) nf[i*W +: W] = part[i];
            frames.push_back(nf);
            part.delete();
         end
      end
      @(negedge clk);
      wr_valid = 1'b0;
      rd_ack   = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      wr_valid = 1'b0;
      rd_ack   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < D; i++) check_eq("rst.rd_frame_zero", 32'(rd_frame[i]), 32'd0);
      check_model("rst");
   endtask

   initial begin
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_data  = '0;
      rd_ack   = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      do_reset();

      // First frame visible one cycle after its last element.
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      step(1'b1, 8'h44, 1'b0);
      #1;
      check_eq("f1.rd_valid", 32'(rd_valid), 32'd1);
      check_eq("f1.elem3",    32'(rd_frame[3]), 32'h44);
      step(1'b0, 8'h00, 1'b0);

      // Both banks full, writer stalled for three cycles.
      do_reset();
      for (int k = 1; k <= 8; k++) step(1'b1, W'(k), 1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, 8'hEE, 1'b0);
      #1;
      check_eq("both.occ",      32'(occ), 32'd2);
      check_eq("both.wr_ready", 32'(wr_ready), 32'd0);
      check_eq("both.elem0",    32'(rd_frame[0]), 32'h01);
`ifdef PINGPONG_ARRAY_CTRL_STALL_CNT_EN
      check_eq("both.stall_cnt", 32'(stall_cnt), 32'd3);
`else
      check_eq("both.stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      // Ack swaps to the second bank.
      step(1'b0, 8'h00, 1'b1);
      #1;
      check_eq("ack.bank_sel", 32'(bank_sel), 32'd1);
      check_eq("ack.elem0",    32'(rd_frame[0]), 32'h05);
      check_eq("ack.occ",      32'(occ), 32'd1);
      step(1'b0, 8'h00, 1'b0);

      // Completion and ack in the same cycle.
      do_reset();
      for (int k = 0; k < 7; k++) step(1'b1, W'(8'h30 + k), 1'b0);
      step(1'b1, 8'h37, 1'b1);
      #1;
      check_eq("same.occ",      32'(occ), 32'd1);
      check_eq("same.bank_sel", 32'(bank_sel), 32'd1);
      check_eq("same.rd_valid", 32'(rd_valid), 32'd1);
      step(1'b0, 8'h00, 1'b0);

      // Reset mid-fill discards the partial frame.
      do_reset();
      step(1'b1, 8'h55, 1'b0);
      step(1'b1, 8'h66, 1'b0);
      do_reset();
      for (int k = 0; k < 4; k++) step(1'b1, W'(8'hA0 + k), 1'b0);
      #1;
      check_eq("mid.elem0",    32'(rd_frame[0]), 32'hA0);
      check_eq("mid.bank_sel", 32'(bank_sel), 32'd0);
      step(1'b0, 8'h00, 1'b0);

      // Ack while empty is ignored.
      do_reset();
      step(1'b1, 8'h71, 1'b0);
      step(1'b1, 8'h72, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h73, 1'b1);
      step(1'b1, 8'h74, 1'b0);
      step(1'b0, 8'h00, 1'b0);

      // Randomized traffic, with phases of slow reader to reach stalls.
      do_reset();
      for (int k = 0; k < 600; k++) begin
         step($urandom_range(0, 3) != 0, W'($urandom),
              (k % 200 < 100) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0));
      end
      // Long stall to exercise saturation.
      for (int k = 0; k < 300; k++) step(1'b1, W'($urandom), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
